// File: rtl/channel_proxy_pkg.sv
// Shared widths and types for the channel proxy and its per-channel FIFOs.
package proxy_pkg;

  localparam int DATA_W = 8;
  localparam int CH_W   = 2;
  localparam int NUM_CH = 1 << CH_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CH_W-1:0]   ch_id_t;

endpackage

// File: rtl/channel_proxy_chan_fifo.sv
// Single-clock synchronous FIFO for one proxy channel; the caller gates push/pop
// with full/empty, and the head output holds the last popped value while empty.
module chan_fifo #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ_q;
  logic [DATA_W-1:0] last_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      if (push && !pop)
        occ_q <= occ_q + OCC_W'(1);
      else if (!push && pop)
        occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign occ   = occ_q;
  assign head  = empty ? last_q : mem[rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/channel_proxy.sv
// Receiving stage for the channel driver: returns ready, routes accepted bytes into
// per-channel FIFOs and keeps a wrapping accept counter per channel.
module channel_proxy
  import proxy_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  CNT_W = 8,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       data,
  input  logic [CH_W-1:0]         channel_id,
  input  logic                    valid,
  output logic                    ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*OCC_W-1:0] occupancy,
  output logic [NUM_CH*CNT_W-1:0] accept_cnt
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // Ready depends only on the addressed channel's fullness, never on valid.
  assign ready = !full[channel_id];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;

    assign push[i]      = valid && ready && (channel_id == ch_id_t'(i));
    assign pop[i]       = !empty[i] && out_ready[i];
    assign out_valid[i] = !empty[i];

    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (data),
      .pop       (pop[i]),
      .head      (out_data[i*DATA_W +: DATA_W]),
      .full      (full[i]),
      .empty     (empty[i]),
      .occ       (occupancy[i*OCC_W +: OCC_W])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q <= '0;
      else if (push[i])
        cnt_q <= cnt_q + CNT_W'(1);
    end

    assign accept_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_channel_proxy.sv
// Directed self-checking bench for channel_proxy: reset, routing, full/ready,
// concurrent push/pop, full-plus-pop refusal, counter wrap and mid-run reset.
module tb_channel_proxy;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic [1:0]  channel_id;
  logic        valid;
  logic        ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [11:0] occupancy;
  logic [31:0] accept_cnt;

  int checks = 0;
  int errors = 0;

  channel_proxy dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .channel_id (channel_id),
    .valid      (valid),
    .ready      (ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input int ch);
    return 32'(out_data[ch*8 +: 8]);
  endfunction

  function automatic logic [31:0] occOf(input int ch);
    return 32'(occupancy[ch*3 +: 3]);
  endfunction

  function automatic logic [31:0] cntOf(input int ch);
    return 32'(accept_cnt[ch*8 +: 8]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [7:0] d,
                               input logic [3:0] ordy);
    valid      = v;
    channel_id = ch;
    data       = d;
    out_ready  = ordy;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);

    // 1. reset asserted mid-clock
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_ready", 32'(ready), 32'h1);
    checkOutput("rst_accept_cnt", accept_cnt, 32'h0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_out_data", out_data, 32'h0);
    nextCycle();
    rst_n = 1'b1;

    // 2. single transfer to channel 2
    applyStimulus(1'b1, 2'd2, 8'd5, 4'b0000);
    #1 checkOutput("single_ready", 32'(ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("single_out_valid", 32'(out_valid), 32'h4);
    checkOutput("single_data", dataOf(2), 32'h5);
    checkOutput("single_cnt", cntOf(2), 32'h1);
    checkOutput("single_occ", occOf(2), 32'h1);
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0100);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("single_pop_valid", 32'(out_valid), 32'h0);
    checkOutput("single_hold_data", dataOf(2), 32'h5);

    // 3. fill channel 1, check ready per channel, then drain in order
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'd1, 8'(10 + k), 4'b0000);
      #1 checkOutput($sformatf("fill_ready_%0d", k), 32'(ready), 32'h1);
      nextCycle();
    end
    applyStimulus(1'b1, 2'd1, 8'd14, 4'b0000);
    #1 checkOutput("full_ready_ch1", 32'(ready), 32'h0);
    checkOutput("full_occ_ch1", occOf(1), 32'h4);
    applyStimulus(1'b1, 2'd0, 8'h20, 4'b0000);
    #1 checkOutput("full_ready_ch0", 32'(ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("ch0_push_occ", occOf(0), 32'h1);
    checkOutput("ch1_no_overflow_occ", occOf(1), 32'h4);
    checkOutput("ch1_cnt", cntOf(1), 32'h4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("drain1_valid_%0d", k), 32'(out_valid[1]), 32'h1);
      checkOutput($sformatf("drain1_data_%0d", k), dataOf(1), 32'(10 + k));
      applyStimulus(1'b0, 2'd0, 8'd0, 4'b0010);
      nextCycle();
    end
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("drain1_occ", occOf(1), 32'h0);

    // 4. concurrent push and pop on channel 0 at occupancy 2
    applyStimulus(1'b1, 2'd0, 8'h21, 4'b0000);
    nextCycle();
    checkOutput("conc_occ_before", occOf(0), 32'h2);
    applyStimulus(1'b1, 2'd0, 8'hAA, 4'b0001);
    #1 checkOutput("conc_old_head", dataOf(0), 32'h20);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0001);
    checkOutput("conc_occ_after", occOf(0), 32'h2);
    checkOutput("conc_new_head", dataOf(0), 32'h21);
    nextCycle();
    checkOutput("conc_head_aa", dataOf(0), 32'hAA);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("conc_drained", occOf(0), 32'h0);
    checkOutput("conc_cnt0", cntOf(0), 32'h3);

    // 5. full channel 3 plus pop: push refused that cycle, accepted the next
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'd3, 8'(8'h30 + k), 4'b0000);
      nextCycle();
    end
    applyStimulus(1'b1, 2'd3, 8'h34, 4'b1000);
    #1 checkOutput("fullpop_ready", 32'(ready), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 2'd3, 8'h34, 4'b0000);
    checkOutput("fullpop_occ3", occOf(3), 32'h3);
    checkOutput("fullpop_head", dataOf(3), 32'h31);
    #1 checkOutput("fullpop_ready_next", 32'(ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("fullpop_occ4", occOf(3), 32'h4);
    checkOutput("fullpop_cnt3", cntOf(3), 32'h5);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("drain3_data_%0d", k), dataOf(3), 32'(8'h31 + k));
      applyStimulus(1'b0, 2'd0, 8'd0, 4'b1000);
      nextCycle();
    end
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("drain3_valid", 32'(out_valid), 32'h0);

    // 6. streaming pushes on ch0 with continuous pop until the counter wraps
    for (int k = 0; k < 253; k++) begin
      applyStimulus(1'b1, 2'd0, 8'(k), 4'b0001);
      nextCycle();
      if (k == 0) checkOutput("wrap_cnt_first", cntOf(0), 32'h4);
    end
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("wrap_cnt0", cntOf(0), 32'h0);
    checkOutput("wrap_occ0", occOf(0), 32'h1);
    checkOutput("wrap_head", dataOf(0), 32'hFC);
    for (int k = 1; k < 3; k++) begin
      applyStimulus(1'b1, 2'd0, 8'(k), 4'b0000);
      nextCycle();
    end
    applyStimulus(1'b0, 2'd0, 8'd0, 4'b0000);
    checkOutput("pre_rst_occ0", occOf(0), 32'h3);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'h1);

    // mid-operation reset takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("midrst_accept_cnt", accept_cnt, 32'h0);
    checkOutput("midrst_out_data", out_data, 32'h0);
    checkOutput("midrst_ready", 32'(ready), 32'h1);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
